// File: rtl/wb_serializer.sv
// Wishbone-mapped MSB-first serializer: DATA/CTRL/STATUS/DIV registers, ACK/ERR one cycle after request.
// No bus stall: every request terminates next cycle; writes while BUSY terminate with ERR and change nothing.
module wb_serializer #(
  parameter int N  = 8,
  parameter int DW = 32
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  input  logic [1:0]    ADR_I,
  input  logic [DW-1:0] DAT_I,
  output logic          ACK_O,
  output logic          ERR_O,
  output logic [DW-1:0] DAT_O,
  output logic          data_o,
  output logic          ena_o
);

  localparam int BW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SHIFT} state_t;

  state_t          state_q, state_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [N-1:0]    data_q, data_d;
  logic [15:0]     div_q, div_d;
  logic            done_q, done_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic [BW-1:0]   bitcnt_q, bitcnt_d;
  logic [15:0]     divcnt_q, divcnt_d;
  logic            dout_q, dout_d;
  logic            ena_q, ena_d;

  logic            req, busy, wr_err, wr_ok, start, last_bit;
  logic [DW-1:0]   rdata;
  logic            unused_dat;

  // A request is only seen while no termination is pending, so a held STB gets one response.
  assign req      = CYC_I & STB_I & ~ack_q & ~err_q;
  assign busy     = (state_q != S_IDLE);
  assign wr_err   = WE_I & ((ADR_I == 2'd2) | busy);
  assign wr_ok    = req & WE_I & ~wr_err;
  assign start    = wr_ok & (ADR_I == 2'd1) & DAT_I[0];
  assign last_bit = (divcnt_q == 16'd0) && (bitcnt_q == BW'(N - 1));
  assign unused_dat = ^DAT_I;

  always_comb begin
    rdata = '0;
    case (ADR_I)
      2'd0:    rdata[N-1:0] = data_q;
      2'd2:    rdata[1:0]   = {done_q, busy};
      2'd3:    rdata[15:0]  = div_q;
      default: rdata        = '0;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      data_q   <= '0;
      div_q    <= '0;
      done_q   <= 1'b0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
      dout_q   <= 1'b0;
      ena_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      data_q   <= data_d;
      div_q    <= div_d;
      done_q   <= done_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
      dout_q   <= dout_d;
      ena_q    <= ena_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FIRST;
      S_FIRST: state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d    = req & ~wr_err;
    err_d    = req & wr_err;
    dat_d    = (req & ~WE_I) ? rdata : '0;
    data_d   = data_q;
    div_d    = div_q;
    done_d   = done_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q;
    dout_d   = dout_q;
    ena_d    = 1'b0;

    if (wr_ok && ADR_I == 2'd0) data_d = DAT_I[N-1:0];
    if (wr_ok && ADR_I == 2'd3) div_d  = DAT_I[15:0];

    case (state_q)
      S_IDLE: begin
        dout_d = 1'b0;
        if (start) begin
          shreg_d = data_q;
          done_d  = 1'b0;
        end
      end
      S_FIRST: begin
        dout_d   = shreg_q[N-1];
        shreg_d  = shreg_q << 1;
        ena_d    = 1'b1;
        divcnt_d = div_q;
        bitcnt_d = '0;
      end
      S_SHIFT: begin
        if (divcnt_q != 16'd0) begin
          divcnt_d = divcnt_q - 16'd1;
        end else if (last_bit) begin
          dout_d = 1'b0;
          done_d = 1'b1;
        end else begin
          dout_d   = shreg_q[N-1];
          shreg_d  = shreg_q << 1;
          ena_d    = 1'b1;
          divcnt_d = div_q;
          bitcnt_d = bitcnt_q + BW'(1);
        end
      end
      default: dout_d = 1'b0;
    endcase
  end

  assign ACK_O  = ack_q;
  assign ERR_O  = err_q;
  assign DAT_O  = dat_q;
  assign data_o = dout_q;
  assign ena_o  = ena_q;

endmodule

// File: tb/tb_wb_serializer.sv
// Bench for wb_serializer: directed and random transfers checked against a cycle-formula model.
module tb_wb_serializer;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int LOGSZ = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc_i, stb_i, we_i;
  logic [1:0]    adr_i;
  logic [DW-1:0] dat_i;
  logic          ack_o, err_o, data_o, ena_o;
  logic [DW-1:0] dat_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic ena_log [0:LOGSZ-1];
  logic dat_log [0:LOGSZ-1];

  wb_serializer #(.N(N), .DW(DW)) dut (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i),
    .ADR_I(adr_i), .DAT_I(dat_i), .ACK_O(ack_o), .ERR_O(err_o), .DAT_O(dat_o),
    .data_o(data_o), .ena_o(ena_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Serial outputs are logged per clock so transfers can be compared after the fact.
  always @(posedge clk) begin
    #1;
    if (cyc < LOGSZ) begin
      ena_log[cyc] = ena_o;
      dat_log[cyc] = data_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [1:0] adr, input logic [31:0] wd,
                     output logic ack, output logic err, output logic [31:0] rd, output int s);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd;
    @(posedge clk); #1;
    ack = ack_o; err = err_o; rd = dat_o; s = cyc;
    @(posedge clk); #1;
    check("single_cycle_term", {30'b0, ack_o, err_o}, 32'd0);
    check("dat_o_zero_after_ack", dat_o, 32'd0);
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [1:0] adr, input logic [31:0] wd, input bit exp_err, input string tag);
    logic a, e; logic [31:0] r; int s;
    bus(1'b1, adr, wd, a, e, r, s);
    check({tag, "_ack"}, a, exp_err ? 32'd0 : 32'd1);
    check({tag, "_err"}, e, exp_err ? 32'd1 : 32'd0);
  endtask

  task automatic rd(input logic [1:0] adr, input logic [31:0] exp, input string tag);
    logic a, e; logic [31:0] r; int s;
    bus(1'b0, adr, 32'd0, a, e, r, s);
    check({tag, "_ack"}, a, 32'd1);
    check({tag, "_err"}, e, 32'd0);
    check({tag, "_dat"}, r, exp);
  endtask

  // Model: bit k occupies cycles s+1+P*k .. s+P*(k+1), ena only on the first of them.
  task automatic xfer(input logic [N-1:0] d, input int dv, input bit inject);
    logic a, e; logic [31:0] r; int s, end_c, o, p;
    logic exp_ena, exp_dat;
    wr(2'd0, {24'b0, d}, 1'b0, "x_wr_data");
    wr(2'd3, dv, 1'b0, "x_wr_div");
    bus(1'b1, 2'd1, 32'd1, a, e, r, s);
    check("x_start_ack", a, 32'd1);
    p = dv + 1;
    end_c = s + p * N + 1;
    if (inject) begin
      wr(2'd0, {24'b0, ~d}, 1'b1, "busy_wr_data");
      wr(2'd1, 32'd1, 1'b1, "busy_start");
      wr(2'd3, 32'd5, 1'b1, "busy_wr_div");
      rd(2'd2, 32'd1, "status_busy");
    end
    while (cyc <= end_c + 1) begin
      @(posedge clk); #1;
    end
    for (int c = s; c <= end_c; c++) begin
      o = c - s - 1;
      if (o < 0 || o >= p * N) begin
        exp_ena = 1'b0; exp_dat = 1'b0;
      end else begin
        exp_ena = ((o % p) == 0);
        exp_dat = d[N - 1 - (o / p)];
      end
      check("trace_ena", {31'b0, ena_log[c]}, {31'b0, exp_ena});
      check("trace_dat", {31'b0, dat_log[c]}, {31'b0, exp_dat});
    end
    rd(2'd2, 32'd2, "status_done");
    rd(2'd0, {24'b0, d}, "data_kept");
    rd(2'd3, dv, "div_kept");
  endtask

  initial begin
    logic a, e; logic [31:0] r; int s, dv;
    logic [N-1:0] d;
    rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = 2'd0; dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {28'b0, ack_o, err_o, data_o, ena_o}, 32'd0);
    check("rst_dat_o", dat_o, 32'd0);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = 2'd2;
    @(posedge clk); #1;
    check("rst_overrides_req", {30'b0, ack_o, err_o}, 32'd0);
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0; rst = 1'b0;

    rd(2'd2, 32'd0, "status_after_rst");
    check("serial_idle", {30'b0, data_o, ena_o}, 32'd0);
    rd(2'd0, 32'd0, "data_after_rst");
    rd(2'd3, 32'd0, "div_after_rst");

    xfer(8'hA5, 0, 1'b0);
    xfer(8'h81, 2, 1'b1);

    wr(2'd2, 32'd3, 1'b1, "wr_status");
    wr(2'd0, 32'h1FF, 1'b0, "wr_data_wide");
    rd(2'd0, 32'hFF, "data_masked");
    wr(2'd1, 32'd0, 1'b0, "ctrl_nostart");
    rd(2'd2, 32'd2, "status_after_ctrl0");
    rd(2'd1, 32'd0, "ctrl_reads0");

    for (int i = 0; i < 6; i++) begin
      d  = N'($urandom);
      dv = $urandom_range(0, 3);
      xfer(d, dv, dv >= 2);
    end

    wr(2'd0, 32'hF0, 1'b0, "ra_wr_data");
    wr(2'd3, 32'd1, 1'b0, "ra_wr_div");
    bus(1'b1, 2'd1, 32'd1, a, e, r, s);
    check("ra_start_ack", a, 32'd1);
    while (cyc < s + 7) begin
      @(posedge clk); #1;
    end
    check("pre_rst_bit3", {30'b0, data_o, ena_o}, 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_abort", {30'b0, data_o, ena_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("no_ena_after_abort", {30'b0, data_o, ena_o}, 32'd0);
    end
    rd(2'd2, 32'd0, "status_after_abort");
    rd(2'd0, 32'd0, "data_after_abort");
    rd(2'd3, 32'd0, "div_after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
